// File: rtl/cla_serial_pkg.sv
// cla_serial_pkg: shared constants and types for the nibble-serial CLA adder.
// Optional overflow output is enabled with `define CLA_SERIAL_OVF_EN.
package cla_serial_pkg;

    localparam int NIB_BITS = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    function automatic int cnt_width(input int nib);
        return (nib > 1) ? $clog2(nib) : 1;
    endfunction

endpackage

// File: rtl/cla_serial_adder_if.sv
// cla_serial_adder_if: operand/result valid-ready bundle for the serial adder.
// Carries ovf only when CLA_SERIAL_OVF_EN is defined.
interface cla_serial_adder_if #(
    parameter int WIDTH = 16
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef CLA_SERIAL_OVF_EN
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
`else
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout
    );
`endif

endinterface

// File: rtl/cla4_slice.sv
// cla4_slice: combinational 4-bit carry-lookahead nibble adder.
// c3 is the carry into bit 3, used for signed overflow detection.
module cla4_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout,
    output logic       c3
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a & b;
    assign p = a ^ b;

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign sum  = p ^ c[3:0];
    assign cout = c[4];
    assign c3   = c[3];

endmodule

// File: rtl/cla_serial_adder.sv
// cla_serial_adder: WIDTH-bit adder built from one CLA nibble slice, LSB first.
// Define CLA_SERIAL_OVF_EN to add the registered two's-complement ovf output.
module cla_serial_adder
    import cla_serial_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    cla_serial_adder_if.slave  bus,
    output logic               busy
);

    localparam int NIB = WIDTH / NIB_BITS;
    localparam int CW  = cnt_width(NIB);

    if ((WIDTH < NIB_BITS) || ((WIDTH % NIB_BITS) != 0)) begin : g_bad_width
        $error("cla_serial_adder: WIDTH must be a multiple of 4 and >= 4");
    end

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_q;
    logic             carry;
    logic             cout_q;
    logic             vld_q;
    logic [CW-1:0]    cnt;
    logic             last;

    logic [3:0]       s_nib;
    logic             c_nib;
    logic             c3;

    logic [WIDTH+NIB_BITS-1:0] sum_cat;
    logic [WIDTH-1:0]          sum_nx;

    cla4_slice u_slice (
        .a    (a_sh[NIB_BITS-1:0]),
        .b    (b_sh[NIB_BITS-1:0]),
        .cin  (carry),
        .sum  (s_nib),
        .cout (c_nib),
        .c3   (c3)
    );

    // New nibble enters at the top; after NIB shifts it lands LSB-aligned.
    assign sum_cat = {s_nib, sum_q};
    assign sum_nx  = sum_cat[WIDTH+NIB_BITS-1:NIB_BITS];
    assign last    = (cnt == CW'(NIB - 1));

    always_comb begin
        state_nx     = state;
        bus.in_ready = 1'b0;
        busy         = 1'b1;
        unique case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                busy         = 1'b0;
                if (bus.in_valid) state_nx = RUN;
            end
            RUN: begin
                if (last) state_nx = DONE;
            end
            DONE: begin
                if (bus.out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_q  <= '0;
            carry  <= 1'b0;
            cout_q <= 1'b0;
            vld_q  <= 1'b0;
            cnt    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_sh  <= bus.a;
                        b_sh  <= bus.b;
                        carry <= bus.cin;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> NIB_BITS;
                    b_sh  <= b_sh >> NIB_BITS;
                    sum_q <= sum_nx;
                    carry <= c_nib;
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        vld_q  <= 1'b1;
                        cout_q <= c_nib;
                    end
                end
                DONE: begin
                    if (bus.out_ready) vld_q <= 1'b0;
                end
                default: vld_q <= 1'b0;
            endcase
        end
    end

`ifdef CLA_SERIAL_OVF_EN
    logic ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if ((state == RUN) && last) begin
            ovf_q <= c3 ^ c_nib;
        end
    end

    assign bus.ovf = ovf_q;
`else
    logic unused_c3;
    assign unused_c3 = c3;
`endif

    assign bus.out_valid = vld_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;

endmodule
